// File: rtl/mem_scan_master_if.sv
// Data-memory bus between mem_scan_master (master) and the data memory (slave).
// Read data is combinational: valid in the same cycle as mem_adr/mem_rd.
interface mem_scan_master_if;
   logic [31:0] mem_adr;
   logic [31:0] mem_wdata;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_rdata;

   modport master (output mem_adr, output mem_wdata, output mem_rd, output mem_wr,
                   input  mem_rdata);
   modport slave  (input  mem_adr, input  mem_wdata, input  mem_rd, input  mem_wr,
                   output mem_rdata);
endinterface

// File: rtl/mem_scan_master.sv
// Array-max accelerator: scans signed 32-bit words, tracks max and first index.
// Optional result write-back to memory is enabled by defining SCAN_WRITEBACK_EN.
module mem_scan_master (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [31:0]               base_adr,
   input  logic [15:0]               count,
   input  logic [31:0]               res_adr,
   mem_scan_master_if.master         bus,
   output logic                      busy,
   output logic                      done,
   output logic [31:0]               max_val,
   output logic [15:0]               max_idx
);

   typedef enum logic [2:0] {IDLE, READ, WR_VAL, WR_IDX, DONE} state_t;

   state_t      state, state_nxt;
   logic [15:0] cnt_q, cnt_nxt;
   logic [15:0] idx_q, idx_nxt;
   logic [31:0] adr_q, adr_nxt;
   logic        rd_q, rd_nxt;
   logic [31:0] max_q, max_nxt;
   logic [15:0] maxi_q, maxi_nxt;

`ifdef SCAN_WRITEBACK_EN
   logic [31:0] res_q, res_nxt;
   logic [31:0] wdata_q, wdata_nxt;
   logic        wr_q, wr_nxt;
`else
   logic        unused_res;
   assign unused_res = ^res_adr;
`endif

   // Next state and next registered outputs; every strobe/address is decoded
   // from the state being entered so the memory sees clean registered signals.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt_q;
      idx_nxt   = idx_q;
      max_nxt   = max_q;
      maxi_nxt  = maxi_q;
      adr_nxt   = '0;
      rd_nxt    = 1'b0;
`ifdef SCAN_WRITEBACK_EN
      res_nxt   = res_q;
      wdata_nxt = '0;
      wr_nxt    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               cnt_nxt  = count;
               idx_nxt  = '0;
               max_nxt  = '0;
               maxi_nxt = '0;
`ifdef SCAN_WRITEBACK_EN
               res_nxt  = res_adr;
`endif
               if (count == 16'd0) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = READ;
                  rd_nxt    = 1'b1;
                  adr_nxt   = base_adr;
               end
            end
         end
         READ: begin
            // Strict signed compare keeps the earliest index on ties.
            if (idx_q == 16'd0 || $signed(bus.mem_rdata) > $signed(max_q)) begin
               max_nxt  = bus.mem_rdata;
               maxi_nxt = idx_q;
            end
            idx_nxt = idx_q + 16'd1;
            if (idx_q == cnt_q - 16'd1) begin
`ifdef SCAN_WRITEBACK_EN
               state_nxt = WR_VAL;
               wr_nxt    = 1'b1;
               adr_nxt   = res_q;
               wdata_nxt = max_nxt;
`else
               state_nxt = DONE;
`endif
            end else begin
               rd_nxt  = 1'b1;
               adr_nxt = adr_q + 32'd4;
            end
         end
`ifdef SCAN_WRITEBACK_EN
         WR_VAL: begin
            state_nxt = WR_IDX;
            wr_nxt    = 1'b1;
            adr_nxt   = res_q + 32'd4;
            wdata_nxt = {16'b0, maxi_q};
         end
         WR_IDX: begin
            state_nxt = DONE;
         end
`endif
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         adr_q   <= '0;
         rd_q    <= 1'b0;
         max_q   <= '0;
         maxi_q  <= '0;
`ifdef SCAN_WRITEBACK_EN
         res_q   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
`endif
      end else begin
         state   <= state_nxt;
         cnt_q   <= cnt_nxt;
         idx_q   <= idx_nxt;
         adr_q   <= adr_nxt;
         rd_q    <= rd_nxt;
         max_q   <= max_nxt;
         maxi_q  <= maxi_nxt;
`ifdef SCAN_WRITEBACK_EN
         res_q   <= res_nxt;
         wdata_q <= wdata_nxt;
         wr_q    <= wr_nxt;
`endif
      end
   end

   assign bus.mem_adr = adr_q;
   assign bus.mem_rd  = rd_q;
`ifdef SCAN_WRITEBACK_EN
   assign bus.mem_wr    = wr_q;
   assign bus.mem_wdata = wdata_q;
`else
   assign bus.mem_wr    = 1'b0;
   assign bus.mem_wdata = '0;
`endif

   assign busy    = (state != IDLE);
   assign done    = (state == DONE);
   assign max_val = max_q;
   assign max_idx = maxi_q;

endmodule

// File: tb/tb_mem_scan_master.sv
// Self-checking bench for mem_scan_master: directed scenarios plus random scans
// compared against a simple array-max reference model and a word memory.
module tb_mem_scan_master;

`ifdef SCAN_WRITEBACK_EN
   localparam bit WB = 1'b1;
`else
   localparam bit WB = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] base_adr;
   logic [15:0] count;
   logic [31:0] res_adr;
   logic        busy;
   logic        done;
   logic [31:0] max_val;
   logic [15:0] max_idx;

   mem_scan_master_if bus_if ();

   mem_scan_master dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .base_adr (base_adr),
      .count    (count),
      .res_adr  (res_adr),
      .bus      (bus_if.master),
      .busy     (busy),
      .done     (done),
      .max_val  (max_val),
      .max_idx  (max_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // 4 KiB word memory, aliased on address bits 11:2
   logic [31:0] mem [1024];
   logic [31:0] model_mem [1024];
   logic        tb_we;
   logic [9:0]  tb_widx;
   logic [31:0] tb_wdata;
   logic [31:0] rd_log [$];
   logic [31:0] wr_log [$];
   int          overlap = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] vals [32];

   assign bus_if.mem_rdata = mem[bus_if.mem_adr[11:2]];

   // Memory write port plus a log of every strobe the master issues
   always @(posedge clk) begin
      if (bus_if.mem_wr)
         mem[bus_if.mem_adr[11:2]] <= bus_if.mem_wdata;
      else if (tb_we)
         mem[tb_widx] <= tb_wdata;
      if (bus_if.mem_rd)
         rd_log.push_back(bus_if.mem_adr);
      if (bus_if.mem_wr)
         wr_log.push_back(bus_if.mem_adr);
      if (bus_if.mem_rd && bus_if.mem_wr)
         overlap <= overlap + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic loadWord(input logic [31:0] a, input logic [31:0] d);
      tb_we    = 1'b1;
      tb_widx  = a[11:2];
      tb_wdata = d;
      model_mem[a[11:2]] = d;
      @(posedge clk);
      #1;
      tb_we = 1'b0;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_adr"},   bus_if.mem_adr, 32'd0);
      checkOutput({tag, "_wdata"}, bus_if.mem_wdata, 32'd0);
      checkOutput({tag, "_rd"},    {31'd0, bus_if.mem_rd}, 32'd0);
      checkOutput({tag, "_wr"},    {31'd0, bus_if.mem_wr}, 32'd0);
      checkOutput({tag, "_busy"},  {31'd0, busy}, 32'd0);
      checkOutput({tag, "_done"},  {31'd0, done}, 32'd0);
      checkOutput({tag, "_maxv"},  max_val, 32'd0);
      checkOutput({tag, "_maxi"},  {16'd0, max_idx}, 32'd0);
   endtask

   // One complete scan: load vals[0..n-1], start, follow to done, check everything
   task automatic applyStimulus(input logic [31:0] base, input int n,
                                input logic [31:0] res, input bit glitch);
      logic [31:0] exp_val;
      logic [15:0] exp_idx;
      int          exp_cyc, cyc, rd0, wr0, nrd, nwr;
      logic [9:0]  ri0, ri1;
      for (int i = 0; i < n; i++)
         loadWord(base + 32'(4 * i), vals[i]);
      loadWord(res, $urandom);
      loadWord(res + 32'd4, $urandom);
      exp_val = 32'd0;
      exp_idx = 16'd0;
      for (int i = 0; i < n; i++) begin
         if (i == 0 || $signed(vals[i]) > $signed(exp_val)) begin
            exp_val = vals[i];
            exp_idx = 16'(i);
         end
      end
      exp_cyc = (n == 0) ? 1 : n + (WB ? 3 : 1);
      rd0 = rd_log.size();
      wr0 = wr_log.size();
      start    = 1'b1;
      base_adr = base;
      count    = 16'(n);
      res_adr  = res;
      @(posedge clk);
      #1;
      start    = glitch;
      base_adr = $urandom;
      count    = 16'($urandom);
      res_adr  = $urandom;
      cyc = 1;
      forever begin
         checkOutput("busy", {31'd0, busy}, 32'd1);
         if (done) break;
         if (cyc >= exp_cyc + 5) break;
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
      end
      start = 1'b0;
      checkOutput("done_cycle", cyc, exp_cyc);
      checkOutput("max_val", max_val, exp_val);
      checkOutput("max_idx", {16'd0, max_idx}, {16'd0, exp_idx});
      nrd = rd_log.size() - rd0;
      nwr = wr_log.size() - wr0;
      checkOutput("rd_count", nrd, n);
      for (int i = 0; i < n && i < nrd; i++)
         checkOutput("rd_adr", rd_log[rd0 + i], base + 32'(4 * i));
      checkOutput("wr_count", nwr, (n > 0 && WB) ? 2 : 0);
      ri0 = res[11:2];
      ri1 = ri0 + 10'd1;
      if (WB && n > 0) begin
         model_mem[ri0] = exp_val;
         model_mem[ri1] = {16'd0, exp_idx};
      end
      checkOutput("mem_res_val", mem[ri0], model_mem[ri0]);
      checkOutput("mem_res_idx", mem[ri1], model_mem[ri1]);
      @(posedge clk);
      #1;
      checkOutput("post_busy", {31'd0, busy}, 32'd0);
      checkOutput("post_done", {31'd0, done}, 32'd0);
      checkOutput("held_max_val", max_val, exp_val);
   endtask

   initial begin
      int          rd0, wr0, n;
      logic [31:0] b, r;
      rst_n    = 1'b0;
      start    = 1'b0;
      base_adr = '0;
      count    = '0;
      res_adr  = '0;
      tb_we    = 1'b0;
      tb_widx  = '0;
      tb_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      checkIdleOutputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      vals[0] = 32'd19; vals[1] = 32'(-64); vals[2] = 32'(-679);
      vals[3] = 32'd1779; vals[4] = 32'd69;
      applyStimulus(32'd1000, 5, 32'd2000, 1'b0);

      vals[0] = 32'(-5); vals[1] = 32'(-3); vals[2] = 32'(-3); vals[3] = 32'(-9);
      applyStimulus(32'd0, 4, 32'd400, 1'b0);

      applyStimulus(32'd100, 0, 32'd500, 1'b0);

      vals[0] = 32'd7; vals[1] = 32'd9; vals[2] = 32'd2;
      applyStimulus(32'hFFFF_FFF8, 3, 32'd2400, 1'b0);

      vals[0] = 32'd19; vals[1] = 32'(-64); vals[2] = 32'(-679);
      vals[3] = 32'd1779; vals[4] = 32'd69;
      applyStimulus(32'd1000, 5, 32'd2000, 1'b1);

      // Abort a 5-element scan with reset in its third cycle
      for (int i = 0; i < 5; i++)
         loadWord(32'd3000 + 32'(4 * i), 32'(10 * (i + 1)));
      loadWord(32'd3600, 32'h1234_5678);
      loadWord(32'd3604, 32'h9ABC_DEF0);
      start    = 1'b1;
      base_adr = 32'd3000;
      count    = 16'd5;
      res_adr  = 32'd3600;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkIdleOutputs("abort");
      rst_n = 1'b1;
      rd0 = rd_log.size();
      wr0 = wr_log.size();
      repeat (8) @(posedge clk);
      #1;
      checkOutput("abort_rd", rd_log.size() - rd0, 0);
      checkOutput("abort_wr", wr_log.size() - wr0, 0);
      checkOutput("abort_mem_val", mem[10'd900], model_mem[10'd900]);
      checkOutput("abort_mem_idx", mem[10'd901], model_mem[10'd901]);
      vals[0] = 32'd4; vals[1] = 32'd8; vals[2] = 32'(-2);
      applyStimulus(32'd3000, 3, 32'd3600, 1'b0);

      for (int t = 0; t < 12; t++) begin
         n = $urandom_range(0, 20);
         for (int i = 0; i < n; i++)
            vals[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
         b = {20'($urandom), 10'($urandom_range(0, 479)), 2'b00};
         r = {20'($urandom), 10'($urandom_range(600, 1000)), 2'b00};
         applyStimulus(b, n, r, 1'($urandom_range(0, 1)));
      end

      checkOutput("rd_wr_overlap", overlap, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
